// File: rtl/staged_kinematics_integrator.sv
// N-stage displacement/velocity integrator: one tick per clock, per-stage accel and
// burn time from packed config buses, with early cut, skipped stages and saturation.
module staged_kinematics_integrator #(
  parameter int unsigned N_STAGES = 3,
  parameter int unsigned W_U      = 5,
  parameter int unsigned W_A      = 3,
  parameter int unsigned W_T      = 3,
  parameter int unsigned W_S      = 16,
  parameter int unsigned W_V      = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ignition,
  input  logic                      cut,
  input  logic [W_U-1:0]            u,
  input  logic [N_STAGES*W_A-1:0]   stage_accel,
  input  logic [N_STAGES*W_T-1:0]   stage_time,
  output logic [W_S-1:0]            s,
  output logic [W_V-1:0]            v,
  output logic [2:0]                stage_idx,
  output logic                      busy,
  output logic                      stage_done,
  output logic                      done,
  output logic                      sat
);

  localparam int unsigned W_Q   = W_A + W_T + 1;
  localparam int unsigned W_M1  = (W_S > W_V) ? W_S : W_V;
  localparam int unsigned W_M   = (W_M1 > W_Q) ? W_M1 : W_Q;
  // Sum of three operands needs headroom beyond the widest of them.
  localparam int unsigned W_SX  = W_M + 2;
  localparam int unsigned W_VX  = ((W_V > W_A) ? W_V : W_A) + 1;

  localparam logic [W_SX-1:0] S_MAX = W_SX'({W_S{1'b1}});
  localparam logic [W_VX-1:0] V_MAX = W_VX'({W_V{1'b1}});
  localparam logic [2:0]      LAST_IDX = 3'(N_STAGES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BURN = 2'd1,
    ST_SEP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [W_S-1:0]   s_q, s_d;
  logic [W_V-1:0]   v_q, v_d;
  logic [W_V-1:0]   v0_q, v0_d;
  logic [W_A-1:0]   a_q, a_d;
  logic [W_T-1:0]   t_q, t_d;
  logic [W_T-1:0]   k_q, k_d;
  logic [W_Q-1:0]   q_q, q_d;
  logic [2:0]       stage_idx_q, stage_idx_d;
  logic             busy_q, busy_d;
  logic             stage_done_q, stage_done_d;
  logic             done_q, done_d;
  logic             sat_q, sat_d;

  logic [W_SX-1:0]  s_sum;
  logic [W_VX-1:0]  v_sum;
  logic [2:0]       nxt_idx;
  int unsigned      nxt_sel;
  logic [W_A-1:0]   nxt_a;
  logic [W_T-1:0]   nxt_t;

  // Next-state and datapath update; everything defaults to hold.
  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    v_d          = v_q;
    v0_d         = v0_q;
    a_d          = a_q;
    t_d          = t_q;
    k_d          = k_q;
    q_d          = q_q;
    stage_idx_d  = stage_idx_q;
    busy_d       = busy_q;
    stage_done_d = 1'b0;
    done_d       = done_q;
    sat_d        = sat_q;

    s_sum   = W_SX'(s_q) + W_SX'(v0_q) + W_SX'(q_q);
    v_sum   = W_VX'(v_q) + W_VX'(a_q);
    nxt_idx = (stage_idx_q == LAST_IDX) ? 3'd0 : stage_idx_q + 3'd1;
    nxt_sel = 32'(nxt_idx);
    nxt_a   = stage_accel[nxt_sel*W_A +: W_A];
    nxt_t   = stage_time[nxt_sel*W_T +: W_T];

    unique case (state_q)
      ST_IDLE: begin
        if (ignition) begin
          state_d     = ST_BURN;
          s_d         = '0;
          v_d         = W_V'(u);
          v0_d        = W_V'(u);
          stage_idx_d = 3'd0;
          a_d         = stage_accel[W_A-1:0];
          t_d         = stage_time[W_T-1:0];
          q_d         = W_Q'(stage_accel[W_A-1:0]);
          k_d         = '0;
          sat_d       = 1'b0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
        end
      end
      ST_BURN: begin
        // A cut wins over the final tick; a zero-length stage skips straight through.
        if (cut || (t_q == '0)) begin
          state_d = ST_SEP;
        end else begin
          if (s_sum > S_MAX) begin
            s_d   = '1;
            sat_d = 1'b1;
          end else begin
            s_d = W_S'(s_sum);
          end
          if (v_sum > V_MAX) begin
            v_d   = '1;
            sat_d = 1'b1;
          end else begin
            v_d = W_V'(v_sum);
          end
          q_d = q_q + (W_Q'(a_q) << 1);
          k_d = k_q + W_T'(1);
          if (k_q == t_q - W_T'(1)) begin
            state_d = ST_SEP;
          end
        end
      end
      ST_SEP: begin
        stage_done_d = 1'b1;
        if (stage_idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d     = ST_BURN;
          stage_idx_d = nxt_idx;
          v0_d        = v_q;
          a_d         = nxt_a;
          t_d         = nxt_t;
          q_d         = W_Q'(nxt_a);
          k_d         = '0;
        end
      end
      ST_DONE: begin
        if (!ignition) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      s_q          <= '0;
      v_q          <= '0;
      v0_q         <= '0;
      a_q          <= '0;
      t_q          <= '0;
      k_q          <= '0;
      q_q          <= '0;
      stage_idx_q  <= 3'd0;
      busy_q       <= 1'b0;
      stage_done_q <= 1'b0;
      done_q       <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      v_q          <= v_d;
      v0_q         <= v0_d;
      a_q          <= a_d;
      t_q          <= t_d;
      k_q          <= k_d;
      q_q          <= q_d;
      stage_idx_q  <= stage_idx_d;
      busy_q       <= busy_d;
      stage_done_q <= stage_done_d;
      done_q       <= done_d;
      sat_q        <= sat_d;
    end
  end

  assign s          = s_q;
  assign v          = v_q;
  assign stage_idx  = stage_idx_q;
  assign busy       = busy_q;
  assign stage_done = stage_done_q;
  assign done       = done_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_staged_kinematics_integrator.sv
// Directed bench for staged_kinematics_integrator: a 16-bit-s instance and an
// 8-bit-s instance share stimulus; expected values are hand-derived.
module tb_staged_kinematics_integrator;

  localparam int unsigned N  = 3;
  localparam int unsigned WU = 5;
  localparam int unsigned WA = 3;
  localparam int unsigned WT = 3;
  localparam int unsigned WV = 10;

  logic              clk;
  logic              rst_n;
  logic              ignition;
  logic              cut;
  logic [WU-1:0]     u;
  logic [N*WA-1:0]   stage_accel;
  logic [N*WT-1:0]   stage_time;

  logic [15:0]       s;
  logic [WV-1:0]     v;
  logic [2:0]        stage_idx;
  logic              busy, stage_done, done, sat;

  logic [7:0]        s8;
  logic [WV-1:0]     v8;
  logic [2:0]        stage_idx8;
  logic              busy8, stage_done8, done8, sat8;

  int n_vec;
  int n_err;

  staged_kinematics_integrator #(
    .N_STAGES(N), .W_U(WU), .W_A(WA), .W_T(WT), .W_S(16), .W_V(WV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ignition(ignition), .cut(cut), .u(u),
    .stage_accel(stage_accel), .stage_time(stage_time),
    .s(s), .v(v), .stage_idx(stage_idx), .busy(busy),
    .stage_done(stage_done), .done(done), .sat(sat)
  );

  staged_kinematics_integrator #(
    .N_STAGES(N), .W_U(WU), .W_A(WA), .W_T(WT), .W_S(8), .W_V(WV)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .ignition(ignition), .cut(cut), .u(u),
    .stage_accel(stage_accel), .stage_time(stage_time),
    .s(s8), .v(v8), .stage_idx(stage_idx8), .busy(busy8),
    .stage_done(stage_done8), .done(done8), .sat(sat8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input int uu, input int a0, input int a1, input int a2,
                     input int t0, input int t1, input int t2);
    u           = WU'(uu);
    stage_accel = {WA'(a2), WA'(a1), WA'(a0)};
    stage_time  = {WT'(t2), WT'(t1), WT'(t0)};
  endtask

  // One-cycle ignition pulse; returns just after launch edge E0.
  task automatic launch();
    ignition = 1'b1;
    step(1);
    ignition = 1'b0;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    ignition = 1'b0;
    cut      = 1'b0;
    cfg(0, 0, 0, 0, 0, 0, 0);
    step(2);
    chk("rst_s", 32'(s), 0);
    chk("rst_v", 32'(v), 0);
    chk("rst_idx", 32'(stage_idx), 0);
    chk("rst_flags", {28'd0, busy, stage_done, done, sat}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // Plan 1: nominal three-stage flight.
    cfg(5, 3, 2, 1, 1, 2, 2);
    launch();
    chk("p1_e0_busy", 32'(busy), 1);
    chk("p1_e0_v", 32'(v), 5);
    chk("p1_e0_s", 32'(s), 0);
    step(1);
    chk("p1_e1_s", 32'(s), 8);
    chk("p1_e1_sd", 32'(stage_done), 0);
    step(1);
    chk("p1_e2_sd", 32'(stage_done), 1);
    chk("p1_e2_sv", {s, 6'd0, v}, {16'd8, 16'd8});
    chk("p1_e2_idx", 32'(stage_idx), 1);
    step(2);
    chk("p1_e4_sd", 32'(stage_done), 0);
    step(1);
    chk("p1_e5_sd", 32'(stage_done), 1);
    chk("p1_e5_sv", {s, 6'd0, v}, {16'd32, 16'd12});
    chk("p1_e5_idx", 32'(stage_idx), 2);
    step(2);
    chk("p1_e7_done", 32'(done), 0);
    step(1);
    chk("p1_e8_sd", 32'(stage_done), 1);
    chk("p1_e8_done", 32'(done), 1);
    chk("p1_e8_busy", 32'(busy), 0);
    chk("p1_e8_sv", {s, 6'd0, v}, {16'd60, 16'd14});
    chk("p1_e8_sat", 32'(sat), 0);
    step(1);
    chk("p1_idle_done", 32'(done), 0);
    chk("p1_idle_s", 32'(s), 60);

    // Plan 2: cut on first tick of stage 1.
    launch();
    step(2);
    chk("p2_e2_s", 32'(s), 8);
    cut = 1'b1;
    step(1);
    cut = 1'b0;
    chk("p2_e3_s", 32'(s), 8);
    chk("p2_e3_v", 32'(v), 8);
    step(1);
    chk("p2_e4_sd", 32'(stage_done), 1);
    chk("p2_e4_idx", 32'(stage_idx), 2);
    step(3);
    chk("p2_e7_done", 32'(done), 1);
    chk("p2_e7_sv", {s, 6'd0, v}, {16'd28, 16'd10});
    step(1);

    // Plan 3: zero-length first and last stages.
    cfg(0, 7, 2, 7, 0, 2, 0);
    launch();
    step(1);
    chk("p3_e1_s", 32'(s), 0);
    step(1);
    chk("p3_e2_sd", 32'(stage_done), 1);
    chk("p3_e2_idx", 32'(stage_idx), 1);
    step(2);
    chk("p3_e4_sv", {s, 6'd0, v}, {16'd8, 16'd4});
    step(1);
    chk("p3_e5_sd", 32'(stage_done), 1);
    step(2);
    chk("p3_e7_sd", 32'(stage_done), 1);
    chk("p3_e7_done", 32'(done), 1);
    chk("p3_e7_sv", {s, 6'd0, v}, {16'd8, 16'd4});
    step(1);

    // Plan 4: saturation on the 8-bit displacement instance.
    cfg(31, 7, 7, 7, 7, 7, 7);
    launch();
    step(24);
    chk("p4_done8", 32'(done8), 1);
    chk("p4_s8", 32'(s8), 255);
    chk("p4_sat8", 32'(sat8), 1);
    chk("p4_v8", 32'(v8), 178);
    chk("p4_s16", 32'(s), 2709);
    chk("p4_sat16", 32'(sat), 0);
    step(1);
    chk("p4_idle_sat8", 32'(sat8), 1);
    cfg(5, 3, 2, 1, 1, 2, 2);
    launch();
    chk("p4_relaunch_sat8", 32'(sat8), 0);
    step(8);
    chk("p4_relaunch_done8", 32'(done8), 1);
    chk("p4_relaunch_s8", 32'(s8), 60);
    step(1);

    // Plan 5: async reset mid-burn, ignition held through release.
    launch();
    step(3);
    chk("p5_e3_s", 32'(s), 18);
    ignition = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk("p5_async_s", 32'(s), 0);
    chk("p5_async_v", 32'(v), 0);
    chk("p5_async_idx", 32'(stage_idx), 0);
    chk("p5_async_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    chk("p5_relaunch_busy", 32'(busy), 1);
    chk("p5_relaunch_v", 32'(v), 5);

    // Plan 6: ignition held through DONE, then re-armed.
    step(8);
    chk("p6_done", 32'(done), 1);
    chk("p6_done_s", 32'(s), 60);
    step(3);
    chk("p6_hold_done", 32'(done), 1);
    chk("p6_hold_busy", 32'(busy), 0);
    chk("p6_hold_sv", {s, 6'd0, v}, {16'd60, 16'd14});
    ignition = 1'b0;
    step(1);
    chk("p6_idle_done", 32'(done), 0);
    chk("p6_idle_s", 32'(s), 60);
    cfg(2, 3, 2, 1, 1, 2, 2);
    launch();
    chk("p6_new_busy", 32'(busy), 1);
    chk("p6_new_s", 32'(s), 0);
    chk("p6_new_v", 32'(v), 2);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
